// File: rtl/keycode_event_decoder.sv
// Turns 4-slot USB HID "keys held" snapshots into an ordered press/release event stream.
// Optional auto-repeat of the most recently pressed key is built when KEY_REPEAT_EN is defined.
module keycode_event_decoder #(
    parameter int STABLE_CYCLES = 1000,
    parameter int FIFO_DEPTH    = 8,
    parameter int REPEAT_DELAY  = 50_000_000,
    parameter int REPEAT_PERIOD = 5_000_000
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic [31:0] keycode_i,
    output logic        ev_valid,
    input  logic        ev_ready,
    output logic [7:0]  ev_code,
    output logic        ev_press,
    output logic        ev_repeat,
    output logic [2:0]  held_count,
    output logic        overflow
);
    localparam int CNT_W = $clog2(STABLE_CYCLES + 1);
    localparam int PTR_W = $clog2(FIFO_DEPTH);

    typedef enum logic [2:0] {IDLE, FILTER, SCAN_REL, SCAN_PRS, COMMIT} state_t;

    state_t           state_reg;
    logic [31:0]      committed_reg;
    logic [31:0]      candidate_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic [1:0]       idx_reg;
    logic [2:0]       held_count_reg;
    logic             overflow_reg;

    logic [7:0] com_byte  [4];
    logic [7:0] cand_byte [4];
    logic [3:0] com_uniq, cand_uniq, com_in_cand, cand_in_com;
    logic [3:0] rel_ok, prs_ok;
    logic [2:0] cand_held;

    for (genvar gi = 0; gi < 4; gi++) begin : g_slot
        assign com_byte[gi]  = committed_reg[8*gi +: 8];
        assign cand_byte[gi] = candidate_reg[8*gi +: 8];
        assign rel_ok[gi]    = com_uniq[gi] & ~com_in_cand[gi];
        assign prs_ok[gi]    = cand_uniq[gi] & ~cand_in_com[gi];
    end

    // A slot counts only if nonzero and not a repeat of an earlier slot in the same snapshot.
    always_comb begin
        com_uniq    = '0;
        cand_uniq   = '0;
        com_in_cand = '0;
        cand_in_com = '0;
        for (int i = 0; i < 4; i++) begin
            com_uniq[i]  = (com_byte[i] != 8'h00);
            cand_uniq[i] = (cand_byte[i] != 8'h00);
            for (int j = 0; j < i; j++) begin
                if (com_byte[j] == com_byte[i])
                    com_uniq[i] = 1'b0;
                if (cand_byte[j] == cand_byte[i])
                    cand_uniq[i] = 1'b0;
            end
            for (int j = 0; j < 4; j++) begin
                if (com_byte[i] == cand_byte[j])
                    com_in_cand[i] = 1'b1;
                if (cand_byte[i] == com_byte[j])
                    cand_in_com[i] = 1'b1;
            end
        end
    end

    assign cand_held = 3'(cand_uniq[0]) + 3'(cand_uniq[1]) + 3'(cand_uniq[2]) + 3'(cand_uniq[3]);

    logic       scan_push;
    logic [7:0] scan_code;
    assign scan_push = ((state_reg == SCAN_REL) && rel_ok[idx_reg]) ||
                       ((state_reg == SCAN_PRS) && prs_ok[idx_reg]);
    assign scan_code = (state_reg == SCAN_PRS) ? cand_byte[idx_reg] : com_byte[idx_reg];

    // Event FIFO: entry = {repeat, press, code}; head is read straight from the storage array.
    logic [9:0]       fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_reg, rd_ptr_reg;
    logic [PTR_W:0]   count_reg;
    logic             full, pop, push_req, push_ok;
    logic [9:0]       push_data, head;
    logic             rep_push_req;
    logic [7:0]       rep_push_code;

    assign full      = (count_reg == (PTR_W+1)'(FIFO_DEPTH));
    assign ev_valid  = (count_reg != '0);
    assign pop       = ev_valid & ev_ready;
    assign push_req  = scan_push | rep_push_req;
    assign push_ok   = push_req & (~full | pop);
    assign push_data = scan_push ? {1'b0, (state_reg == SCAN_PRS), scan_code}
                                 : {1'b1, 1'b1, rep_push_code};
    assign head      = ev_valid ? fifo_mem[rd_ptr_reg] : 10'd0;
    assign ev_repeat = head[9];
    assign ev_press  = head[8];
    assign ev_code   = head[7:0];

    always_ff @(posedge Clk) begin
        if (push_ok)
            fifo_mem[wr_ptr_reg] <= push_data;
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push_ok)
                wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            if (pop)
                rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            case ({push_ok, pop})
                2'b10:   count_reg <= count_reg + (PTR_W+1)'(1);
                2'b01:   count_reg <= count_reg - (PTR_W+1)'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_reg      <= IDLE;
            committed_reg  <= '0;
            candidate_reg  <= '0;
            cnt_reg        <= '0;
            idx_reg        <= '0;
            held_count_reg <= '0;
            overflow_reg   <= 1'b0;
        end else begin
            if (scan_push && full && !pop)
                overflow_reg <= 1'b1;
            case (state_reg)
                IDLE: begin
                    if (keycode_i != committed_reg) begin
                        state_reg     <= FILTER;
                        candidate_reg <= keycode_i;
                        cnt_reg       <= CNT_W'(1);
                    end
                end
                FILTER: begin
                    if (keycode_i == committed_reg) begin
                        state_reg <= IDLE;
                    end else if (keycode_i != candidate_reg) begin
                        candidate_reg <= keycode_i;
                        cnt_reg       <= CNT_W'(1);
                    end else if (cnt_reg == CNT_W'(STABLE_CYCLES)) begin
                        state_reg <= SCAN_REL;
                        idx_reg   <= '0;
                    end else begin
                        cnt_reg <= cnt_reg + CNT_W'(1);
                    end
                end
                SCAN_REL: begin
                    idx_reg <= idx_reg + 2'd1;
                    if (idx_reg == 2'd3)
                        state_reg <= SCAN_PRS;
                end
                SCAN_PRS: begin
                    idx_reg <= idx_reg + 2'd1;
                    if (idx_reg == 2'd3)
                        state_reg <= COMMIT;
                end
                COMMIT: begin
                    committed_reg  <= candidate_reg;
                    held_count_reg <= cand_held;
                    state_reg      <= IDLE;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign held_count = held_count_reg;
    assign overflow   = overflow_reg;

`ifdef KEY_REPEAT_EN
    logic [7:0]  rep_code_reg;
    logic        rep_active_reg, rep_first_reg, rep_pend_reg, scan_evt_reg;
    logic [31:0] rep_timer_reg, rep_limit;

    assign rep_limit     = rep_first_reg ? 32'(REPEAT_DELAY - 1) : 32'(REPEAT_PERIOD - 1);
    assign rep_push_req  = rep_pend_reg & ~scan_push;
    assign rep_push_code = rep_code_reg;

    // Later assignments win: a release of the repeat key overrides a timer expiry in the same cycle.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            rep_code_reg   <= '0;
            rep_active_reg <= 1'b0;
            rep_first_reg  <= 1'b0;
            rep_pend_reg   <= 1'b0;
            scan_evt_reg   <= 1'b0;
            rep_timer_reg  <= '0;
        end else begin
            if (rep_push_req)
                rep_pend_reg <= 1'b0;
            if (rep_active_reg) begin
                if (rep_timer_reg == rep_limit) begin
                    rep_timer_reg <= '0;
                    rep_first_reg <= 1'b0;
                    rep_pend_reg  <= 1'b1;
                end else begin
                    rep_timer_reg <= rep_timer_reg + 32'd1;
                end
            end
            if (scan_push) begin
                scan_evt_reg <= 1'b1;
                if (state_reg == SCAN_REL && scan_code == rep_code_reg) begin
                    rep_active_reg <= 1'b0;
                    rep_pend_reg   <= 1'b0;
                end
                if (state_reg == SCAN_PRS) begin
                    rep_code_reg   <= scan_code;
                    rep_active_reg <= 1'b1;
                end
            end
            if (state_reg == COMMIT) begin
                scan_evt_reg <= 1'b0;
                if (scan_evt_reg) begin
                    rep_timer_reg <= '0;
                    rep_first_reg <= 1'b1;
                    rep_pend_reg  <= 1'b0;
                end
            end
        end
    end
`else
    assign rep_push_req  = 1'b0;
    assign rep_push_code = 8'h00;
`endif

endmodule
